// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle sequencing controller: FSM states,
// opcode map, ALU operation codes and PC source selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_EXEC_I   = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WB   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_HALT     = 4'd13
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_ANDI  = 4'b0010;
  localparam logic [3:0] OP_ORI   = 4'b0011;
  localparam logic [3:0] OP_LW    = 4'b0100;
  localparam logic [3:0] OP_SW    = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_J     = 4'b0111;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;

  localparam logic [1:0] PC_PLUS1  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // DECODE successor for an opcode; S_IDLE marks an undefined opcode.
  function automatic state_t decode_next(input logic [3:0] op);
    case (op)
      OP_RTYPE:                 return S_EXEC_R;
      OP_ADDI, OP_ANDI, OP_ORI: return S_EXEC_I;
      OP_LW, OP_SW:             return S_MEM_ADDR;
      OP_BEQ:                   return S_BRANCH;
      OP_J:                     return S_JUMP;
      OP_HALT:                  return S_HALT;
      default:                  return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl.sv
// Moore sequencing FSM stepping each instruction through fetch/decode/execute/
// memory/writeback, with a retired-instruction counter and sticky illegal flag.
module multi_cycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             i_or_d,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic             ext_op,
  output logic [2:0]       alu_op,
  output logic [3:0]       state,
  output logic             halted,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  state_t           r_state;
  state_t           w_next;
  logic             w_retire;
  logic             w_illegal;
  logic             r_illegal;
  logic [CNT_W-1:0] r_count;

  // Memory handshake: mem_req/mem_we/i_or_d are pure state decode, so they
  // hold steady across wait cycles; the access completes in the cycle where
  // mem_ready is high, and mem_ready is ignored in every other state.
  always_comb begin
    w_next    = S_IDLE;
    w_retire  = 1'b0;
    w_illegal = 1'b0;
    case (r_state)
      S_IDLE:     w_next = en ? S_FETCH : S_IDLE;
      S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        w_next = decode_next(opcode);
        if (w_next == S_IDLE) begin
          w_illegal = 1'b1;
          w_next    = en ? S_FETCH : S_IDLE;
        end
      end
      S_EXEC_R:   w_next = S_WB_R;
      S_EXEC_I:   w_next = S_WB_I;
      S_MEM_ADDR: w_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   w_next = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR: begin
        w_next   = S_MEM_WR;
        w_retire = mem_ready;
      end
      S_WB_R, S_WB_I, S_MEM_WB, S_BRANCH, S_JUMP: w_retire = 1'b1;
      S_HALT:     w_next = S_HALT;
      default:    w_next = S_IDLE;
    endcase
    if (w_retire) begin
      w_next = en ? S_FETCH : S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_retire) begin
        r_count <= r_count + CNT_W'(1);
      end
      if (w_illegal) begin
        r_illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_PLUS1;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    ext_op     = 1'b0;
    alu_op     = ALU_ADD;
    halted     = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
        pc_we   = mem_ready;
      end
      S_DECODE, S_MEM_ADDR: begin
        alu_src = 1'b1;
        ext_op  = 1'b1;
      end
      S_EXEC_R: alu_op = ALU_FUNCT;
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_EXEC_I: begin
        alu_src = 1'b1;
        case (opcode)
          OP_ANDI: alu_op = ALU_AND;
          OP_ORI:  alu_op = ALU_OR;
          default: ext_op = 1'b1;
        endcase
      end
      S_WB_I: reg_write = 1'b1;
      S_MEM_RD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
      end
      S_BRANCH: begin
        alu_op = ALU_SUB;
        pc_src = PC_BRANCH;
        pc_we  = zero;
      end
      S_JUMP: begin
        pc_we  = 1'b1;
        pc_src = PC_JUMP;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign state       = r_state;
  assign illegal_op  = r_illegal;
  assign instr_count = r_count;

endmodule
